viterbi_rx_checker: RTL

//  Receive-end checker for the convolutional encode/decode link. Buffers every
//  bit offered to encoder2, pairs it in order with each bit produced by the

---
 rtl/viterbi_rx_checker_if.sv | 16 +
 rtl/viterbi_rx_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/viterbi_rx_checker_if.sv
// Tap bundle between the tx/rx link harness and the receive-end checker.
// Handshake: these are observe-only taps with no ready/backpressure. A bit is
// transferred on every rising clk edge where its *_valid_i is 1, and the
// matching *_bit_i is sampled on that same edge. The checker never stalls the
// link.
interface viterbi_rx_checker_if;
  logic tx_valid_i;
  logic tx_bit_i;
  logic rx_valid_i;
  logic rx_bit_i;

  // Harness side drives the taps.
  modport master (output tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i);
  // Checker side observes them.
  modport slave  (input  tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i);
endinterface

// File: rtl/viterbi_rx_checker.sv
// Receive-end checker. Buffers every tx bit in a FIFO, pairs each decoder
// output bit with the oldest buffered tx bit, and counts mismatches. It also
// measures link latency and flags loss of sync and FIFO overflow/underflow.
module viterbi_rx_checker #(
  parameter int DEPTH    = 64,
  parameter int SKIP     = 0,
  parameter int NUM_BITS = 256,
  parameter int LOSS_THR = 8,
  parameter int CW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  viterbi_rx_checker_if.slave    link,
  output logic [CW-1:0]          bit_err_ct_o,
  output logic [CW-1:0]          checked_ct_o,
  output logic [CW-1:0]          latency_o,
  output logic                   lat_valid_o,
  output logic                   sync_lost_o,
  output logic                   ovf_o,
  output logic                   unf_o,
  output logic                   done_o,
  output logic [1:0]             state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] SKIP_C = CW'(SKIP);
  localparam logic [CW-1:0] NUM_C  = CW'(NUM_BITS);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS_THR);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   err_ct_q, err_ct_d, chk_ct_q, chk_ct_d;
  logic [CW-1:0]   lat_q, lat_d, lat_ct_q, lat_ct_d;
  logic [CW-1:0]   consec_q, consec_d, skip_ct_q, skip_ct_d;
  logic            lat_valid_q, lat_valid_d, lat_run_q, lat_run_d;
  logic            sync_lost_q, sync_lost_d, ovf_q, ovf_d, unf_q, unf_d;

  logic active, empty, full, head, rx_ev, tx_ev, pop, push, mismatch;
  logic [CW-1:0] elapsed;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Next-state: FSM, FIFO pointers (pop before push), counters and sticky flags.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_ct_d    = err_ct_q;
    chk_ct_d    = chk_ct_q;
    lat_d       = lat_q;
    lat_ct_d    = lat_ct_q;
    lat_valid_d = lat_valid_q;
    lat_run_d   = lat_run_q;
    consec_d    = consec_q;
    skip_ct_d   = skip_ct_q;
    sync_lost_d = sync_lost_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    mismatch    = 1'b0;

    active  = (state_q == S_SKIP) || (state_q == S_CHECK);
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head    = mem_q[rd_ptr_q[AW-1:0]];
    rx_ev   = active && link.rx_valid_i;
    tx_ev   = active && link.tx_valid_i;
    pop     = rx_ev && !empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    push    = tx_ev && (!full || pop);
    // Cycles since the first push; 0 on the push cycle itself.
    elapsed = lat_run_q ? lat_ct_q : '0;

    if (start_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      err_ct_d    = '0;
      chk_ct_d    = '0;
      lat_d       = '0;
      lat_ct_d    = '0;
      lat_valid_d = 1'b0;
      lat_run_d   = 1'b0;
      consec_d    = '0;
      skip_ct_d   = '0;
      sync_lost_d = 1'b0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      state_d     = (SKIP > 0) ? S_SKIP : S_CHECK;
    end else begin
      if (rx_ev && empty)         unf_d = 1'b1;
      if (tx_ev && full && !pop)  ovf_d = 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = link.tx_bit_i;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (lat_run_q) lat_ct_d = sat_inc(lat_ct_q);
      else if (push) begin
        lat_run_d = 1'b1;
        lat_ct_d  = CW'(1);
      end
      if (rx_ev && !lat_valid_q) begin
        lat_d       = elapsed;
        lat_valid_d = 1'b1;
      end

      case (state_q)
        S_SKIP: begin
          // Warm-up decoder outputs are discarded along with their tx bits.
          if (rx_ev) begin
            skip_ct_d = skip_ct_q + CW'(1);
            if (skip_ct_d == SKIP_C) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (pop) begin
            mismatch = head ^ link.rx_bit_i;
            chk_ct_d = sat_inc(chk_ct_q);
            if (mismatch) begin
              err_ct_d = sat_inc(err_ct_q);
              if (consec_q != LOSS_C) consec_d = consec_q + CW'(1);
              if (consec_d == LOSS_C) sync_lost_d = 1'b1;
            end else begin
              consec_d = '0;
            end
            if ((NUM_BITS != 0) && (chk_ct_d == NUM_C)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset aborts any run and discards all results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_ct_q    <= '0;
      chk_ct_q    <= '0;
      lat_q       <= '0;
      lat_ct_q    <= '0;
      lat_valid_q <= 1'b0;
      lat_run_q   <= 1'b0;
      consec_q    <= '0;
      skip_ct_q   <= '0;
      sync_lost_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_ct_q    <= err_ct_d;
      chk_ct_q    <= chk_ct_d;
      lat_q       <= lat_d;
      lat_ct_q    <= lat_ct_d;
      lat_valid_q <= lat_valid_d;
      lat_run_q   <= lat_run_d;
      consec_q    <= consec_d;
      skip_ct_q   <= skip_ct_d;
      sync_lost_q <= sync_lost_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bit_err_ct_o = err_ct_q;
  assign checked_ct_o = chk_ct_q;
  assign latency_o    = lat_q;
  assign lat_valid_o  = lat_valid_q;
  assign sync_lost_o  = sync_lost_q;
  assign ovf_o        = ovf_q;
  assign unf_o        = unf_q;
  assign done_o       = (state_q == S_DONE);
  assign state_o      = state_q;

endmodule
